// File: rtl/mux16_pkg.sv
// Shared constants and lane-offset helper for the 16-to-1 selector.
// Lane 0 sits in the most significant slice of the packed input.
package mux16_pkg;

    localparam int N_LANES = 16;
    localparam int SEL_W   = 4;
    localparam int GROUP   = 4;
    localparam int N_GROUP = N_LANES / GROUP;

    // LSB position of lane k in a packed bus of N_LANES lanes of given width
    function automatic int lane_lsb(input int k, input int width);
        return (N_LANES - 1 - k) * width;
    endfunction

endpackage

// File: rtl/mux4_to_1.sv
// Four-lane selector used as the building block of the 16-lane tree.
// Lane 0 occupies the most significant WIDTH bits of in.
module mux4_to_1 #(
    parameter int WIDTH = 1
) (
    input  logic [4*WIDTH-1:0] in,
    input  logic [1:0]         sel,
    output logic [WIDTH-1:0]   out
);

    always_comb begin
        out = '0;
        unique case (sel)
            2'd0: out = in[3*WIDTH +: WIDTH];
            2'd1: out = in[2*WIDTH +: WIDTH];
            2'd2: out = in[1*WIDTH +: WIDTH];
            2'd3: out = in[0*WIDTH +: WIDTH];
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/mux16_to_1.sv
// 16-to-1 lane selector with combinational output and a registered,
// valid-qualified copy (1-cycle latency).
module mux16_to_1
    import mux16_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_LANES*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    output logic [WIDTH-1:0]         out_comb,
    output logic [WIDTH-1:0]         out,
    output logic                     out_valid
);

    logic [N_GROUP-1:0][WIDTH-1:0] mid;
    logic [WIDTH-1:0]              sel_lane;

    // First level: group g holds lanes 4g..4g+3, lowest lane is 4g+3
    for (genvar g = 0; g < N_GROUP; g++) begin : g_lvl1
        mux4_to_1 #(.WIDTH(WIDTH)) u_mux (
            .in  (in[lane_lsb(GROUP*g + GROUP - 1, WIDTH) +: GROUP*WIDTH]),
            .sel (sel[1:0]),
            .out (mid[g])
        );
    end

    mux4_to_1 #(.WIDTH(WIDTH)) u_lvl2 (
        .in  ({mid[0], mid[1], mid[2], mid[3]}),
        .sel (sel[3:2]),
        .out (sel_lane)
    );

    assign out_comb = sel_lane;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= sel_lane;
            end
        end
    end

endmodule

// File: tb/tb_mux16_to_1.sv
// Randomised self-checking bench for mux16_to_1 at WIDTH=1 and WIDTH=8.
// Reference model computes lane[sel] by shifting the packed input.
module tb_mux16_to_1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [15:0]  in1;
    logic [3:0]   sel1;
    logic         iv1;
    logic         oc1, o1, ov1;

    logic [127:0] in8;
    logic [3:0]   sel8;
    logic         iv8;
    logic [7:0]   oc8, o8;
    logic         ov8;

    logic         e1, ev1;
    logic [7:0]   e8;
    logic         ev8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux16_to_1 #(.WIDTH(1)) d1 (
        .clk(clk), .rst(rst), .in(in1), .sel(sel1), .in_valid(iv1),
        .out_comb(oc1), .out(o1), .out_valid(ov1)
    );

    mux16_to_1 #(.WIDTH(8)) d8 (
        .clk(clk), .rst(rst), .in(in8), .sel(sel8), .in_valid(iv8),
        .out_comb(oc8), .out(o8), .out_valid(ov8)
    );

    function automatic logic ref1(input logic [15:0] v, input int k);
        logic [15:0] s;
        s = v >> (15 - k);
        return s[0];
    endfunction

    function automatic logic [7:0] ref8(input logic [127:0] v, input int k);
        logic [127:0] s;
        s = v >> ((15 - k) * 8);
        return s[7:0];
    endfunction

    // Advance one clock and update the expected registered outputs
    task automatic tick();
        logic       n1, v1, v8;
        logic [7:0] n8;
        n1 = ref1(in1, int'(sel1));
        v1 = iv1;
        n8 = ref8(in8, int'(sel8));
        v8 = iv8;
        @(posedge clk);
        #1;
        if (!rst) begin
            ev1 = v1;
            if (v1) e1 = n1;
            ev8 = v8;
            if (v8) e8 = n8;
        end
    endtask

    task automatic test_reset();
        in1 = 16'h8000; sel1 = 4'd0; iv1 = 1'b0;
        in8 = '0;       sel8 = 4'd0; iv8 = 1'b0;
        e1 = 1'b0; ev1 = 1'b0; e8 = '0; ev8 = 1'b0;
        #1;
        n_cmp++;
        if (o1 !== 1'b0 || ov1 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_w1 out=%b valid=%b exp 0 0", o1, ov1);
        end
        n_cmp++;
        if (o8 !== 8'h00 || ov8 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_w8 out=%h valid=%b exp 00 0", o8, ov8);
        end
        n_cmp++;
        if (oc1 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_comb out_comb=%b exp 1", oc1);
        end
        tick();
        #1 rst = 1'b0;
    endtask

    task automatic test_walk();
        for (int k = 0; k < 16; k++) begin
            in1 = 16'h8000 >> k; sel1 = 4'(k); iv1 = 1'b1;
            #1;
            n_cmp++;
            if (oc1 !== 1'b1) begin
                n_bad++;
                $display("FAIL walk_comb k=%0d got %b exp 1", k, oc1);
            end
            tick();
            n_cmp++;
            if (o1 !== 1'b1 || ov1 !== 1'b1) begin
                n_bad++;
                $display("FAIL walk_reg k=%0d out=%b valid=%b exp 1 1",
                         k, o1, ov1);
            end
        end
    endtask

    task automatic test_wrong_lane();
        logic [15:0] pat [3];
        logic [3:0]  sl  [3];
        logic        ex  [3];
        pat[0] = 16'h8000; sl[0] = 4'd1;  ex[0] = 1'b0;
        pat[1] = 16'h0001; sl[1] = 4'd15; ex[1] = 1'b1;
        pat[2] = 16'hFFFE; sl[2] = 4'd15; ex[2] = 1'b0;
        iv1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in1 = pat[i]; sel1 = sl[i];
            #1;
            n_cmp++;
            if (oc1 !== ex[i]) begin
                n_bad++;
                $display("FAIL wrong_lane in=%h sel=%0d got %b exp %b",
                         pat[i], sl[i], oc1, ex[i]);
            end
        end
        in1 = 16'bx; in1[15] = 1'b1; sel1 = 4'd0;
        #1;
        n_cmp++;
        if (oc1 !== 1'b1) begin
            n_bad++;
            $display("FAIL x_unselected got %b exp 1", oc1);
        end
        tick();
    endtask

    task automatic test_hold();
        in1 = 16'h4000; sel1 = 4'd1; iv1 = 1'b1;
        tick();
        n_cmp++;
        if (o1 !== 1'b1 || ov1 !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_load out=%b valid=%b exp 1 1", o1, ov1);
        end
        in1 = 16'h0000; iv1 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (o1 !== 1'b1 || ov1 !== 1'b0 || oc1 !== 1'b0) begin
                n_bad++;
                $display("FAIL hold c=%0d out=%b valid=%b comb=%b exp 1 0 0",
                         c, o1, ov1, oc1);
            end
        end
    endtask

    task automatic test_async_reset();
        in1 = 16'h8000; sel1 = 4'd0; iv1 = 1'b1;
        tick();
        n_cmp++;
        if (o1 !== 1'b1 || ov1 !== 1'b1) begin
            n_bad++;
            $display("FAIL areset_pre out=%b valid=%b exp 1 1", o1, ov1);
        end
        #1 rst = 1'b1;
        #1;
        e1 = 1'b0; ev1 = 1'b0; e8 = '0; ev8 = 1'b0;
        n_cmp++;
        if (o1 !== 1'b0 || ov1 !== 1'b0 || oc1 !== 1'b1) begin
            n_bad++;
            $display("FAIL areset out=%b valid=%b comb=%b exp 0 0 1",
                     o1, ov1, oc1);
        end
        #1 rst = 1'b0;
        tick();
        n_cmp++;
        if (o1 !== e1 || ov1 !== ev1) begin
            n_bad++;
            $display("FAIL areset_post out=%b valid=%b exp %b %b",
                     o1, ov1, e1, ev1);
        end
    endtask

    task automatic test_width8();
        for (int k = 0; k < 16; k++) in8[(15 - k) * 8 +: 8] = 8'(8'h11 * k);
        for (int k = 0; k < 16; k++) begin
            sel8 = 4'(k); iv8 = 1'b1;
            #1;
            n_cmp++;
            if (oc8 !== 8'(8'h11 * k)) begin
                n_bad++;
                $display("FAIL w8_comb k=%0d got %h exp %h",
                         k, oc8, 8'(8'h11 * k));
            end
            tick();
            n_cmp++;
            if (o8 !== 8'(8'h11 * k) || ov8 !== 1'b1) begin
                n_bad++;
                $display("FAIL w8_reg k=%0d out=%h valid=%b exp %h 1",
                         k, o8, ov8, 8'(8'h11 * k));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            in1  = 16'($urandom);
            sel1 = 4'($urandom_range(0, 15));
            iv1  = 1'($urandom_range(0, 1));
            in8  = {$urandom, $urandom, $urandom, $urandom};
            sel8 = 4'($urandom_range(0, 15));
            iv8  = 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if (oc1 !== ref1(in1, int'(sel1))) begin
                n_bad++;
                $display("FAIL rnd_comb1 i=%0d got %b exp %b",
                         i, oc1, ref1(in1, int'(sel1)));
            end
            n_cmp++;
            if (oc8 !== ref8(in8, int'(sel8))) begin
                n_bad++;
                $display("FAIL rnd_comb8 i=%0d got %h exp %h",
                         i, oc8, ref8(in8, int'(sel8)));
            end
            tick();
            n_cmp++;
            if (o1 !== e1 || ov1 !== ev1) begin
                n_bad++;
                $display("FAIL rnd_reg1 i=%0d out=%b valid=%b exp %b %b",
                         i, o1, ov1, e1, ev1);
            end
            n_cmp++;
            if (o8 !== e8 || ov8 !== ev8) begin
                n_bad++;
                $display("FAIL rnd_reg8 i=%0d out=%h valid=%b exp %h %b",
                         i, o8, ov8, e8, ev8);
            end
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_wrong_lane();
        test_hold();
        test_async_reset();
        test_width8();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
